alu_64: RTL and testbench
=========================

// Module: alu_64
// PURPOSE
//   Y86-64 integer ALU used by the pipeline execute stage (OPq and address/stack arithmetic).
//   Combinational 2-bit-opcode datapath producing result and overflow with zero latency.
//   Owns the architectural condition-code register (ZF/SF/OF): one clock, asynchronous active-low reset.
//   Execute stage reads result combinationally in the same cycle; CC updates land on the next clk edge.
// PARAMETERS
//   WIDTH  64  operand/result width in bits (two's complement); all rules below scale with WIDTH
// PORTS
//   clk            in   1      rising-edge clock, CC register only
//   rst_n          in   1      asynchronous active-low reset
//   control        in   2      op select: 00 add, 01 sub, 10 and, 11 xor
//   a              in   WIDTH  operand A (Y86 valA / rA)
//   b              in   WIDTH  operand B (Y86 valB / rB)
//   cc_en          in   1      load ZF/SF/OF from current result on next rising clk
//   ansfinal       out  WIDTH  result, combinational
//   overflowfinal  out  1      signed overflow of current op, combinational
//   zf             out  1      registered zero flag
//   sf             out  1      registered sign flag
//   of             out  1      registered overflow flag
// BEHAVIOUR
//   - Result, combinational, no clock involvement:
//       00: ansfinal = a + b (mod 2^WIDTH)
//       01: ansfinal = b - a (Y86 subq rA,rB semantics: rB - rA), computed as b + ~a + 1
//       10: ansfinal = a & b
//       11: ansfinal = a ^ b
//   - overflowfinal:
//       add: (a[MSB]==b[MSB]) && (ansfinal[MSB]!=a[MSB])
//       sub: (b[MSB]!=a[MSB]) && (ansfinal[MSB]!=b[MSB])
//       and/xor: 0
//   - Carry-out is discarded; no carry flag.
//   - Adder/subtractor may be behavioural or structural (ripple or lookahead).
//   - Full WIDTH-bit add must settle within one clk period.
//   - CC register:
//       async clear on rst_n=0: zf=0, sf=0, of=0, immediate, independent of clk
//       posedge clk with rst_n=1 and cc_en=1: zf<=(ansfinal==0), sf<=ansfinal[MSB], of<=overflowfinal
//       cc_en=0: flags hold
//   - rst_n deasserted mid-operation: combinational outputs unaffected; flags remain 0 until next enabled edge.
//   - Inputs X/undriven are not supported; callers drive control=00 and a=b=0 when idle.
//   - Flags are the sole state; ansfinal/overflowfinal have no reset value (pure functions of inputs).
// TESTING
//   - Add: control=00, a=5, b=7 -> ansfinal=12, overflowfinal=0; cc_en=1 edge -> zf=0 sf=0 of=0.
//   - Add overflow: a=b=64'h7FFF_FFFF_FFFF_FFFF -> ansfinal=64'hFFFF_FFFF_FFFF_FFFE, overflowfinal=1;
//       after edge -> sf=1 of=1 zf=0.
//   - Sub: control=01, a=3, b=10 -> ansfinal=7.
//   - Sub zero: a=b=9 -> ansfinal=0; after edge -> zf=1.
//   - Sub overflow: a=1, b=64'h8000_0000_0000_0000 -> ansfinal=64'h7FFF_FFFF_FFFF_FFFF, overflowfinal=1.
//   - Logic ops: a=64'hF0F0, b=64'hFF00 -> and=64'hF000, xor=64'h0FF0, overflowfinal=0.
//   - Hold with cc_en=0: change inputs, clock -> flags unchanged.
//   - Async reset: assert rst_n=0 between edges -> flags 0 immediately.

Source files
------------

// File: rtl/alu_64.sv
// alu_64: Y86-64 execute-stage ALU with combinational result/overflow and registered ZF/SF/OF
module alu_64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cc_en,
  output logic [WIDTH-1:0] ansfinal,
  output logic             overflowfinal,
  output logic             zf,
  output logic             sf,
  output logic             of
);
  localparam int M = WIDTH - 1;
  logic [WIDTH-1:0] sum, diff;
  // result and signed overflow; sub is b - a as b + ~a + 1
  always_comb begin
    sum = a + b;
    diff = b + ~a + WIDTH'(1);
    ansfinal = control == 2'b00 ? sum : control == 2'b01 ? diff : control == 2'b10 ? a & b : a ^ b;
    overflowfinal = control == 2'b00 ? (a[M] == b[M]) && (sum[M] != a[M]) :
                    control == 2'b01 ? (b[M] != a[M]) && (diff[M] != b[M]) : 1'b0;
  end
  // condition codes: async clear, load from current result when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf <= 1'b0;
      sf <= 1'b0;
      of <= 1'b0;
    end else if (cc_en) begin
      zf <= ansfinal == '0;
      sf <= ansfinal[M];
      of <= overflowfinal;
    end
  end
endmodule

// File: tb/tb_alu_64.sv
// tb_alu_64: randomized self-checking bench for alu_64 against an arithmetic reference model
module tb_alu_64;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  control;
  logic [63:0] a, b;
  logic        cc_en;
  logic [63:0] ansfinal;
  logic        overflowfinal, zf, sf, of;
  int tests = 0;
  int fails = 0;
  logic ezf, esf, eof;

  alu_64 dut (
    .clk(clk), .rst_n(rst_n), .control(control), .a(a), .b(b), .cc_en(cc_en),
    .ansfinal(ansfinal), .overflowfinal(overflowfinal), .zf(zf), .sf(sf), .of(of)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] c, input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] r, output logic v);
    logic signed [65:0] w;
    w = '0;
    if (c == 2'd0) w = 66'(signed'(x)) + 66'(signed'(y));
    if (c == 2'd1) w = 66'(signed'(y)) - 66'(signed'(x));
    if (c[1]) begin
      r = c[0] ? x ^ y : x & y;
      v = 1'b0;
    end else begin
      r = w[63:0];
      v = w != 66'(signed'(r));
    end
  endfunction

  task automatic lit(input string tag, input logic [1:0] c, input logic [63:0] x, input logic [63:0] y,
                     input logic [63:0] er, input logic ev);
    control = c; a = x; b = y; cc_en = 1'b0;
    #1;
    chk({tag, "_ans"}, ansfinal, er);
    chk({tag, "_ovf"}, overflowfinal, ev);
  endtask

  task automatic step(input logic [1:0] c, input logic [63:0] x, input logic [63:0] y, input logic en);
    logic [63:0] r;
    logic v;
    control = c; a = x; b = y; cc_en = en;
    model(c, x, y, r, v);
    #1;
    chk("ans", ansfinal, r);
    chk("ovf", overflowfinal, v);
    @(posedge clk);
    #1;
    if (en) begin
      ezf = r == 64'd0;
      esf = r[63];
      eof = v;
    end
    chk("zf", zf, ezf);
    chk("sf", sf, esf);
    chk("of", of, eof);
  endtask

  function automatic logic [63:0] pick();
    int k;
    k = $urandom_range(0, 7);
    return k == 0 ? 64'd0 : k == 1 ? 64'h7FFF_FFFF_FFFF_FFFF : k == 2 ? 64'h8000_0000_0000_0000 :
           k == 3 ? '1 : k == 4 ? 64'($urandom_range(0, 15)) : {$urandom, $urandom};
  endfunction

  initial begin
    rst_n = 1'b0; control = 2'b00; a = '0; b = '0; cc_en = 1'b0;
    ezf = 1'b0; esf = 1'b0; eof = 1'b0;
    #3;
    chk("rst_zf", zf, 1'b0);
    chk("rst_sf", sf, 1'b0);
    chk("rst_of", of, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    lit("add", 2'b00, 64'd5, 64'd7, 64'd12, 1'b0);
    lit("addov", 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    lit("sub", 2'b01, 64'd3, 64'd10, 64'd7, 1'b0);
    lit("subz", 2'b01, 64'd9, 64'd9, 64'd0, 1'b0);
    lit("subov", 2'b01, 64'd1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    lit("and", 2'b10, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0);
    lit("xor", 2'b11, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0);
    step(2'b00, 64'd5, 64'd7, 1'b1);
    chk("add_flags", {zf, sf, of}, 3'b000);
    step(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    chk("addov_flags", {zf, sf, of}, 3'b011);
    step(2'b11, 64'd1, 64'd1, 1'b0);
    chk("hold_flags", {zf, sf, of}, 3'b011);
    step(2'b01, 64'd9, 64'd9, 1'b1);
    chk("subz_flags", {zf, sf, of}, 3'b100);
    step(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    control = 2'b10; a = 64'hF0F0; b = 64'hFF00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_zf", zf, 1'b0);
    chk("arst_sf", sf, 1'b0);
    chk("arst_of", of, 1'b0);
    chk("arst_ans", ansfinal, 64'hF000);
    #1;
    rst_n = 1'b1;
    ezf = 1'b0; esf = 1'b0; eof = 1'b0;
    step(2'b01, 64'd1, 64'h8000_0000_0000_0000, 1'b0);
    for (int i = 0; i < 300; i++) step(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
